alu_issue_queue: RTL and testbench

//  Upstream feeder for the ALU. Buffers instruction_t words from a loader in a circular FIFO
//  and issues at most one per cycle onto the ALU IW input through an output register.

---
 rtl/alu_issue_queue_pkg.sv | 29 ++
 rtl/alu_tag_pipe.sv | 43 ++++
 rtl/alu_issue_queue.sv | 108 ++++++++++
 tb/tb_alu_issue_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_queue_pkg
//  Description : Shared ALU instruction word, opcode and issue-tag definitions.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_queue_pkg;

    localparam int TAG_W_DEFAULT       = 8;
    localparam int ALU_LATENCY_DEFAULT = 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } opcode_t;

    typedef struct packed {
        opcode_t    op;
        logic [7:0] a;
        logic [7:0] b;
    } instruction_t;

    typedef logic [TAG_W_DEFAULT-1:0] tag_t;

endpackage
`default_nettype wire

// File: rtl/alu_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_tag_pipe
//  Description : Valid+tag delay line matching the ALU result latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_tag_pipe #(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    logic [LATENCY-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [LATENCY];

    // Only reset clears in-flight stages; a flush upstream lets them drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_tag[0]   <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign out_tag   = r_tag[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_queue
//  Description : Circular instruction FIFO issuing tagged words to the ALU IW.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ALU_LATENCY = ALU_LATENCY_DEFAULT,
    parameter int TAG_W       = TAG_W_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  instruction_t               in_word,
    input  logic                       flush,
    input  logic                       issue_en,
    output instruction_t               IW,
    output logic                       iw_valid,
    output logic [TAG_W-1:0]           iw_tag,
    output logic                       result_valid,
    output logic [TAG_W-1:0]           result_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    instruction_t       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    instruction_t       r_iw;
    logic               r_iw_valid;
    logic [TAG_W-1:0]   r_iw_tag;
    logic [TAG_W-1:0]   r_next_tag;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == c_cnt_w'(DEPTH));
    assign in_ready = !w_full;
    // Fullness is judged before any pop, so a full queue never takes a word.
    assign w_push   = in_valid && !w_full && !flush;
    assign w_pop    = (r_count != '0) && issue_en && !flush;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_iw       <= '0;
            r_iw_valid <= 1'b0;
            r_iw_tag   <= '0;
            r_next_tag <= '0;
        end else begin
            r_iw_valid <= w_pop;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
            // IW and its tag hold their last value on idle or flushed cycles.
            if (w_pop) begin
                r_iw       <= r_mem[r_rd_ptr];
                r_iw_tag   <= r_next_tag;
                r_next_tag <= r_next_tag + TAG_W'(1);
            end
        end
    end

    alu_tag_pipe #(
        .LATENCY (ALU_LATENCY),
        .TAG_W   (TAG_W)
    ) u_tag_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (r_iw_valid),
        .in_tag    (r_iw_tag),
        .out_valid (result_valid),
        .out_tag   (result_tag)
    );

    assign IW       = r_iw;
    assign iw_valid = r_iw_valid;
    assign iw_tag   = r_iw_tag;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_queue
//  Description : Scoreboard bench for alu_issue_queue with a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = 1;
    localparam int TAG_W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    instruction_t in_word;
    logic         flush;
    logic         issue_en;
    instruction_t IW;
    logic         iw_valid;
    logic [TAG_W-1:0] iw_tag;
    logic         result_valid;
    logic [TAG_W-1:0] result_tag;
    logic [$clog2(DEPTH+1)-1:0] count;

    alu_issue_queue #(.DEPTH(DEPTH), .ALU_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .flush        (flush),
        .issue_en     (issue_en),
        .IW           (IW),
        .iw_valid     (iw_valid),
        .iw_tag       (iw_tag),
        .result_valid (result_valid),
        .result_tag   (result_tag),
        .count        (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        instruction_t w;
        int           tag;
        int           due;
    } exp_t;

    exp_t         exp_iw[$];
    exp_t         exp_res[$];
    instruction_t mfifo[$];
    instruction_t src[$];
    int  next_tag = 0;
    int  cyc      = 0;
    bit  model_acc = 0;
    bit  started   = 0;
    int  checks = 0;
    int  errors = 0;
    logic [7:0] alu_res;

    function automatic logic [7:0] alu_fn(instruction_t w);
        case (w.op)
            OP_ADD:  return w.a + w.b;
            OP_SUB:  return w.a - w.b;
            OP_AND:  return w.a & w.b;
            OP_OR:   return w.a | w.b;
            OP_XOR:  return w.a ^ w.b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s cycle=%0d", name, cyc);
    endtask

    // ALU stand-in: one registered stage on IW.
    always @(posedge clock) alu_res <= alu_fn(IW);

    // Reference model: a plain word queue plus a running tag counter.
    always @(posedge clock) begin : model
        exp_t e;
        bit   was_full;
        cyc++;
        model_acc = 1'b0;
        if (reset) begin
            mfifo.delete();
            exp_iw.delete();
            exp_res.delete();
            next_tag = 0;
            started  = 1'b1;
        end else if (flush) begin
            mfifo.delete();
        end else begin
            was_full = (mfifo.size() == DEPTH);
            if (mfifo.size() != 0 && issue_en) begin
                e.w   = mfifo.pop_front();
                e.tag = next_tag;
                e.due = cyc;
                exp_iw.push_back(e);
                e.due = cyc + LAT;
                exp_res.push_back(e);
                next_tag = (next_tag + 1) % (1 << TAG_W);
            end
            if (in_valid && !was_full) begin
                mfifo.push_back(in_word);
                model_acc = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (started) begin
            chk("count", 32'(count), 32'(mfifo.size()));
            chk("in_ready", 32'(in_ready), 32'(mfifo.size() < DEPTH));
            if (iw_valid) begin
                if (exp_iw.size() == 0) begin
                    fail_now("iw_unexpected");
                end else begin
                    e = exp_iw.pop_front();
                    chk("iw_tag", 32'(iw_tag), 32'(e.tag));
                    chk("iw_word", 32'(IW), 32'(e.w));
                    chk("iw_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (exp_iw.size() != 0 && exp_iw[0].due <= cyc) begin
                void'(exp_iw.pop_front());
                fail_now("iw_missing");
            end
            if (result_valid) begin
                if (exp_res.size() == 0) begin
                    fail_now("result_unexpected");
                end else begin
                    e = exp_res.pop_front();
                    chk("result_tag", 32'(result_tag), 32'(e.tag));
                    chk("result_cycle", 32'(cyc), 32'(e.due));
                    chk("alu_result", 32'(alu_res), 32'(alu_fn(e.w)));
                end
            end else if (exp_res.size() != 0 && exp_res[0].due <= cyc) begin
                void'(exp_res.pop_front());
                fail_now("result_missing");
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic instruction_t rand_word();
        instruction_t w;
        w.op = opcode_t'($urandom_range(0, 4));
        w.a  = 8'($urandom);
        w.b  = 8'($urandom);
        return w;
    endfunction

    // Loader: holds src[0] until the model reports it accepted.
    task automatic run(int n, int pv, int pi, int pf);
        for (int i = 0; i < n; i++) begin
            reset    = 1'b0;
            in_valid = (src.size() != 0) && ($urandom_range(0, 99) < pv);
            in_word  = (src.size() != 0) ? src[0] : '0;
            issue_en = ($urandom_range(0, 99) < pi);
            flush    = ($urandom_range(0, 99) < pf);
            step();
            if (model_acc) void'(src.pop_front());
        end
        in_valid = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic fill_and_launch_one();
        run(10, 0, 100, 0);
        for (int i = 0; i < 6; i++) src.push_back(rand_word());
        run(6, 100, 0, 0);
        chk("fill6_count", 32'(count), 32'd6);
        run(1, 0, 100, 0);
        chk("launch_iw_valid", 32'(iw_valid), 32'd1);
        chk("launch_count", 32'(count), 32'd5);
        src.delete();
        src.push_back(rand_word());
    endtask

    initial begin
        instruction_t w;
        reset = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; issue_en = 1'b0;
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_iw", 32'(IW), 32'd0);
        chk("rst_iw_valid", 32'(iw_valid), 32'd0);
        chk("rst_iw_tag", 32'(iw_tag), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result_tag", 32'(result_tag), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        w.op = OP_ADD; w.a = 8'd5; w.b = 8'd7;
        src.push_back(w);
        run(1, 100, 100, 0);
        run(4, 0, 100, 0);

        for (int i = 0; i < 9; i++) src.push_back(rand_word());
        run(10, 100, 0, 0);
        chk("full_count", 32'(count), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("held_ninth", 32'(src.size()), 32'd1);
        run(12, 100, 100, 0);

        for (int i = 0; i < 3; i++) src.push_back(rand_word());
        run(3, 100, 0, 0);
        for (int i = 0; i < 6; i++) src.push_back(rand_word());
        run(6, 100, 100, 0);
        chk("pushpop_count", 32'(count), 32'd3);
        run(6, 0, 100, 0);

        for (int i = 0; i < 260; i++) src.push_back(rand_word());
        for (int i = 0; i < 2000 && src.size() != 0; i++) run(1, 90, 80, 0);
        if (src.size() != 0) fail_now("stream_timeout");
        src.delete();
        run(12, 0, 100, 0);

        for (int i = 0; i < 200; i++) src.push_back(rand_word());
        run(600, 85, 70, 3);
        src.delete();
        run(12, 0, 100, 0);

        fill_and_launch_one();
        in_valid = 1'b1; in_word = src[0]; flush = 1'b1; issue_en = 1'b1;
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_iw_valid", 32'(iw_valid), 32'd0);
        src.delete();
        run(4, 0, 100, 0);

        fill_and_launch_one();
        in_valid = 1'b1; in_word = src[0]; reset = 1'b1; issue_en = 1'b1;
        step();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_iw_valid", 32'(iw_valid), 32'd0);
        chk("reset_result_valid", 32'(result_valid), 32'd0);
        src.delete();
        run(4, 0, 100, 0);

        @(negedge clock);
        #1;
        if (exp_iw.size() != 0) fail_now("iw_leftover");
        if (exp_res.size() != 0) fail_now("result_leftover");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
